// File: rtl/ctx_restore_engine_pkg.sv
// Shared types and widths for the context restore engine.
package ctx_pkg;
  localparam int NUM_THREADS_DEF = 4;
  localparam int NUM_REGS_DEF    = 32;
  localparam int DATA_W_DEF      = 32;
  localparam int TID_W           = $clog2(NUM_THREADS_DEF);
  localparam int IDX_W           = $clog2(NUM_REGS_DEF);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  typedef logic [DATA_W_DEF-1:0] ctx_word_t;
endpackage

// File: rtl/ctx_restore_engine_if.sv
// Restored-word stream from the engine to the core register-file write port.
interface ctx_restore_engine_if
  import ctx_pkg::*;
#(
  parameter int TW = TID_W,
  parameter int IW = IDX_W,
  parameter int DW = DATA_W_DEF
);
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] out_tid;
  logic [IW-1:0] out_idx;
  logic [DW-1:0] out_data;
  logic          out_last;

  modport master (
    output out_valid, out_tid, out_idx, out_data, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_tid, out_idx, out_data, out_last,
    output out_ready
  );
endinterface

// File: rtl/ctx_restore_engine_store_mem.sv
// Per-thread saved-register storage: one synchronous write port, one asynchronous read port.
module ctx_store_mem #(
  parameter  int NUM_THREADS = 4,
  parameter  int NUM_REGS    = 32,
  parameter  int DATA_W      = 32,
  localparam int TW          = $clog2(NUM_THREADS),
  localparam int IW          = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [TW-1:0]     wr_tid,
  input  logic [IW-1:0]     wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [TW-1:0]     rd_tid,
  input  logic [IW-1:0]     rd_idx,
  output logic [DATA_W-1:0] rd_data
);
  // Not reset: saved contexts are only trusted through the ctx_valid flags.
  logic [DATA_W-1:0] mem [NUM_THREADS*NUM_REGS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[{wr_tid, wr_idx}] <= wr_data;
    end
  end

  assign rd_data = mem[{rd_tid, rd_idx}];
endmodule

// File: rtl/ctx_restore_engine.sv
// Restores a saved thread context to the register file as a valid/ready word stream.
// state  | meaning
// IDLE   | ready for a restore request; saves go straight to memory
// STREAM | streaming mem[tid][idx] out; saves to tid are dropped
module ctx_restore_engine
  import ctx_pkg::*;
#(
  parameter  int NUM_THREADS = 4,
  parameter  int NUM_REGS    = 32,
  parameter  int DATA_W      = 32,
  localparam int TW          = $clog2(NUM_THREADS),
  localparam int IW          = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   save_valid,
  input  logic [TW-1:0]          save_tid,
  input  logic [IW-1:0]          save_idx,
  input  logic [DATA_W-1:0]      save_data,
  output logic                   save_conflict,
  input  logic                   restore_req,
  input  logic [TW-1:0]          restore_tid,
  output logic                   restore_ready,
  output logic                   restore_done,
  output logic                   restore_err,
  output logic [NUM_THREADS-1:0] ctx_valid,
  ctx_restore_engine_if.master   rf_port
);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REGS - 1);

  state_t           state_q, state_d;
  logic [TW-1:0]    tid_q, tid_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [NUM_THREADS-1:0] ctx_valid_q;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             conflict_q, conflict;
  logic             final_hs;
  logic             mem_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tid_q      <= '0;
      idx_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tid_q      <= tid_d;
      idx_q      <= idx_d;
      done_q     <= done_d;
      err_q      <= err_d;
      conflict_q <= conflict;
    end
  end

  always_comb begin
    state_d  = state_q;
    tid_d    = tid_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    final_hs = 1'b0;
    case (state_q)
      IDLE: begin
        if (restore_req) begin
          // Decision uses the flags as they stood before any same-cycle save.
          if (ctx_valid_q[restore_tid]) begin
            state_d = STREAM;
            tid_d   = restore_tid;
            idx_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      STREAM: begin
        if (rf_port.out_ready) begin
          if (idx_q == LAST_IDX) begin
            final_hs = 1'b1;
            state_d  = IDLE;
            done_d   = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A save into the context being streamed would tear it, so it is dropped.
  assign conflict = save_valid && (state_q == STREAM) && (save_tid == tid_q);
  assign mem_we   = save_valid && !conflict;

  always_ff @(posedge clk) begin
    if (rst) begin
      ctx_valid_q <= '0;
    end else begin
      if (mem_we && save_idx == '0) begin
        ctx_valid_q[save_tid] <= 1'b0;
      end
      if (mem_we && save_idx == LAST_IDX) begin
        ctx_valid_q[save_tid] <= 1'b1;
      end
      if (final_hs) begin
        ctx_valid_q[tid_q] <= 1'b0;
      end
    end
  end

  ctx_store_mem #(
    .NUM_THREADS (NUM_THREADS),
    .NUM_REGS    (NUM_REGS),
    .DATA_W      (DATA_W)
  ) u_store (
    .clk     (clk),
    .we      (mem_we),
    .wr_tid  (save_tid),
    .wr_idx  (save_idx),
    .wr_data (save_data),
    .rd_tid  (tid_q),
    .rd_idx  (idx_q),
    .rd_data (rf_port.out_data)
  );

  assign rf_port.out_valid = (state_q == STREAM);
  assign rf_port.out_tid   = tid_q;
  assign rf_port.out_idx   = idx_q;
  assign rf_port.out_last  = (state_q == STREAM) && (idx_q == LAST_IDX);

  assign restore_ready = (state_q == IDLE);
  assign restore_done  = done_q;
  assign restore_err   = err_q;
  assign save_conflict = conflict_q;
  assign ctx_valid     = ctx_valid_q;
endmodule
